ex_mem_wb_backend: RTL and testbench
====================================

Name: ex_mem_wb_backend

Overview:
- Back end of the ARMv8 five-stage pipeline. It consumes the ID/EX register outputs produced by decode.
- Implements:
  - Execute: operand forwarding, ALU.
  - EX/MEM pipeline register.
  - Memory: on-chip 64-bit data memory.
  - MEM/WB pipeline register.
  - Write-back mux.
- Drives the register-file write port (WriteReg/WriteData/RegWrite) back into decode, closing the loop decode reads from.

Parameters:
- DEPTH, 256, number of 64-bit data-memory words (power of two).
- AW, 8, log2(DEPTH); data-memory word-index width.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- ALUSrc_Ex  in  1  1: ALU B operand = SignExt_Ex; 0: forwarded register operand
- ALUOp_Ex  in  3  ALU function select
- MemRead_Ex  in  1  load in EX
- MemWrite_Ex  in  1  store in EX
- MemtoReg_Ex  in  1  1: write back load data; 0: ALU result
- RegWrite_Ex  in  1  instruction writes Rd
- Rd_Ex  in  5  destination / store-data register index
- Rn_Ex  in  5  read-port-1 register index
- Rm_Ex  in  5  read-port-2 register index (decode supplies the Reg2Loc-selected index)
- SignExt_Ex  in  64  sign-extended immediate
- ReadData1_Ex  in  64  register-file port-1 data
- ReadData2_Ex  in  64  register-file port-2 data
- Zero_Ex  out  1  ALU result == 0 (combinational, EX)
- ALUResult_Mem  out  64  EX/MEM ALU result (debug / branch use)
- Rd_Mem  out  5  EX/MEM destination index
- WriteReg  out  5  register-file write index (from MEM/WB)
- WriteData  out  64  register-file write data
- RegWrite  out  1  register-file write enable

Behaviour:
- Reset low, asynchronous:
  - All EX/MEM and MEM/WB fields clear to 0, so RegWrite=0, WriteReg=0, WriteData=0, Rd_Mem=0, ALUResult_Mem=0.
  - Data memory contents unaffected.
- Reset asserted mid-operation: in-flight loads/stores/writes are dropped. A store in MEM at the reset edge does not commit.
- Forwarding, A operand (Rn_Ex):
  - EX/MEM when RegWrite_M && Rd_M!=31 && Rd_M==Rn_Ex.
  - Else MEM/WB when RegWrite_W && Rd_W!=31 && Rd_W==Rn_Ex.
  - Else ReadData1_Ex.
- Forwarding, B register operand: identical, using Rm_Ex and ReadData2_Ex. EX/MEM has priority over MEM/WB.
- Operand B = ALUSrc_Ex ? SignExt_Ex : forwarded B. Store data = forwarded B (pre-ALUSrc mux).
- ALUOp encoding; ALU is 64-bit, wrap-around, no flags other than Zero:
  - 000 AND
  - 001 ORR
  - 010 ADD
  - 110 SUB (A-B)
  - 111 pass B
  - others: result 0
- EX/MEM latch each edge: ALU result, store data, Rd, MemRead, MemWrite, MemtoReg, RegWrite.
- Memory stage:
  - Word index = ALUResult_M[AW+2:3]. Upper bits ignored, so addresses wrap modulo DEPTH*8. Low 3 bits ignored (no misalignment trap).
  - Store: mem[index] <= store data at the edge while MemWrite_M=1.
  - Load: combinational read, captured into MEM/WB.
  - Load and store to the same index in consecutive cycles: the load sees the stored value (store commits before the following load's MEM cycle).
- MEM/WB latch: load data, ALU result, Rd, MemtoReg, RegWrite.
- Write-back, combinational from MEM/WB:
  - WriteData = MemtoReg_W ? load data : ALU result.
  - WriteReg = Rd_W.
  - RegWrite = RegWrite_W && Rd_W!=31 (XZR writes suppressed).
- Latency: instruction present on *_Ex inputs during cycle n → RegWrite asserted during cycle n+2 → register file updated at end of cycle n+2.
- Bubbles: all-zero control inputs (as inserted by the hazard stall mux) propagate as no-ops; no memory write, no register write.
- MemRead_M && MemWrite_M both 1 (illegal): the write commits; load data is the old value.

Optional Feature:
- Macro BACKEND_FORWARDING_EN.
- Defined: forwarding as above.
- Undefined:
  - A/B operands taken directly from ReadData1_Ex/ReadData2_Ex.
  - Forwarding comparators absent.
  - Software or decode must insert two bubbles between dependent instructions.
  - All other behaviour identical.

Test Plan:
- Reset mid-stream: Reset low for 1 cycle while ADD is in MEM → RegWrite=0, WriteData=0 immediately (async); no write-back for that ADD afterwards.
- ADD X1 with ReadData1=5, SignExt=7, ALUSrc=1, ALUOp=010, Rd=1, RegWrite=1 → two edges later RegWrite=1, WriteReg=1, WriteData=12.
- Back-to-back dependency with forwarding enabled:
  - SUB X2=X1-X1 directly after ADD X1=12 (stale ReadData1/ReadData2=0) → Zero_Ex=1, WriteData=0 for X2.
  - ORR X3=X1|X2 next → X1 is taken from MEM/WB.
- STUR: store 64'hDEAD_BEEF to address 0x18 (index 3), then LDUR X4 from address 0x18+DEPTH*8 → wraps to index 3; WriteReg=4, WriteData=64'hDEAD_BEEF.
- Write to XZR: ADD with Rd=31, RegWrite=1 → RegWrite output stays 0; no forwarding from it into a following instruction reading X31.
- Compile without BACKEND_FORWARDING_EN, then repeat the dependency test → X2 result uses stale operands (WriteData=0 for SUB of 0-0; ORR yields 0).

Source files
------------

// File: rtl/ex_mem_wb_backend.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_wb_backend
// Brief    : Execute / memory / write-back back end of the five-stage ARMv8
//            pipeline: operand forwarding, 64-bit ALU, EX/MEM register,
//            on-chip data memory, MEM/WB register and write-back mux.
// Options  : BACKEND_FORWARDING_EN - enables EX/MEM and MEM/WB operand
//            forwarding; when undefined, operands come straight from decode.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_wb_backend #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        ALUSrc_Ex,
  input  logic [2:0]  ALUOp_Ex,
  input  logic        MemRead_Ex,
  input  logic        MemWrite_Ex,
  input  logic        MemtoReg_Ex,
  input  logic        RegWrite_Ex,
  input  logic [4:0]  Rd_Ex,
  input  logic [4:0]  Rn_Ex,
  input  logic [4:0]  Rm_Ex,
  input  logic [63:0] SignExt_Ex,
  input  logic [63:0] ReadData1_Ex,
  input  logic [63:0] ReadData2_Ex,
  output logic        Zero_Ex,
  output logic [63:0] ALUResult_Mem,
  output logic [4:0]  Rd_Mem,
  output logic [4:0]  WriteReg,
  output logic [63:0] WriteData,
  output logic        RegWrite
);

  localparam logic [4:0] XZR = 5'd31;

  // EX/MEM pipeline register
  logic [63:0] alu_m_q, store_m_q;
  logic [4:0]  rd_m_q;
  logic        memread_m_q, memwrite_m_q, memtoreg_m_q, regwrite_m_q;
  // MEM/WB pipeline register
  logic [63:0] load_w_q, alu_w_q;
  logic [4:0]  rd_w_q;
  logic        memtoreg_w_q, regwrite_w_q;

  logic [63:0] mem_q [DEPTH];
  logic [63:0] op_a, fwd_b, op_b, alu_d, load_d, wb_data;
  logic [AW-1:0] mem_idx;

  assign wb_data = memtoreg_w_q ? load_w_q : alu_w_q;

`ifdef BACKEND_FORWARDING_EN
  // Operand selection: newest producer (EX/MEM) wins over MEM/WB; XZR never forwards
  always_comb begin
    op_a  = ReadData1_Ex;
    fwd_b = ReadData2_Ex;
    if (regwrite_m_q && rd_m_q != XZR && rd_m_q == Rn_Ex)
      op_a = alu_m_q;
    else if (regwrite_w_q && rd_w_q != XZR && rd_w_q == Rn_Ex)
      op_a = wb_data;
    if (regwrite_m_q && rd_m_q != XZR && rd_m_q == Rm_Ex)
      fwd_b = alu_m_q;
    else if (regwrite_w_q && rd_w_q != XZR && rd_w_q == Rm_Ex)
      fwd_b = wb_data;
  end
`else
  // Without forwarding, decode/software guarantees two bubbles between dependents
  always_comb begin
    op_a  = ReadData1_Ex;
    fwd_b = ReadData2_Ex;
  end
  logic unused_fwd_idx;
  assign unused_fwd_idx = ^{Rn_Ex, Rm_Ex};
`endif

  assign op_b = ALUSrc_Ex ? SignExt_Ex : fwd_b;

  // 64-bit wrap-around ALU; undefined opcodes produce zero
  always_comb begin
    alu_d = 64'd0;
    case (ALUOp_Ex)
      3'b000:  alu_d = op_a & op_b;
      3'b001:  alu_d = op_a | op_b;
      3'b010:  alu_d = op_a + op_b;
      3'b110:  alu_d = op_a - op_b;
      3'b111:  alu_d = op_b;
      default: alu_d = 64'd0;
    endcase
  end

  assign Zero_Ex = (alu_d == 64'd0);

  // EX/MEM capture; reset drops whatever instruction is in flight
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      alu_m_q      <= 64'd0;
      store_m_q    <= 64'd0;
      rd_m_q       <= 5'd0;
      memread_m_q  <= 1'b0;
      memwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      regwrite_m_q <= 1'b0;
    end else begin
      alu_m_q      <= alu_d;
      store_m_q    <= fwd_b;
      rd_m_q       <= Rd_Ex;
      memread_m_q  <= MemRead_Ex;
      memwrite_m_q <= MemWrite_Ex;
      memtoreg_m_q <= MemtoReg_Ex;
      regwrite_m_q <= RegWrite_Ex;
    end
  end

  // Byte address -> word index; high bits wrap, low three bits ignored
  assign mem_idx = alu_m_q[AW+2:3];
  // Load is a combinational read, so a load alongside a store sees the old word
  assign load_d  = mem_q[mem_idx];

  // Data memory write; contents survive reset, but no store commits while reset is low
  always_ff @(posedge clk) begin
    if (Reset && memwrite_m_q)
      mem_q[mem_idx] <= store_m_q;
  end

  // MEM/WB capture
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      load_w_q     <= 64'd0;
      alu_w_q      <= 64'd0;
      rd_w_q       <= 5'd0;
      memtoreg_w_q <= 1'b0;
      regwrite_w_q <= 1'b0;
    end else begin
      load_w_q     <= load_d;
      alu_w_q      <= alu_m_q;
      rd_w_q       <= rd_m_q;
      memtoreg_w_q <= memtoreg_m_q;
      regwrite_w_q <= regwrite_m_q;
    end
  end

  // MemRead only matters to the hazard unit upstream; the read port is always live
  logic unused_memread;
  assign unused_memread = memread_m_q;

  assign ALUResult_Mem = alu_m_q;
  assign Rd_Mem        = rd_m_q;
  assign WriteReg      = rd_w_q;
  assign WriteData     = wb_data;
  assign RegWrite      = regwrite_w_q && (rd_w_q != XZR);

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_wb_backend.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_wb_backend
// Brief    : Directed self-checking bench for ex_mem_wb_backend. Expectations
//            follow BACKEND_FORWARDING_EN when the bench is built with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_wb_backend;

  logic        clk, Reset;
  logic        ALUSrc_Ex, MemRead_Ex, MemWrite_Ex, MemtoReg_Ex, RegWrite_Ex;
  logic [2:0]  ALUOp_Ex;
  logic [4:0]  Rd_Ex, Rn_Ex, Rm_Ex;
  logic [63:0] SignExt_Ex, ReadData1_Ex, ReadData2_Ex;
  logic        Zero_Ex, RegWrite;
  logic [63:0] ALUResult_Mem, WriteData;
  logic [4:0]  Rd_Mem, WriteReg;

  int errors = 0;
  int checks = 0;

  ex_mem_wb_backend #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .Reset(Reset),
    .ALUSrc_Ex(ALUSrc_Ex), .ALUOp_Ex(ALUOp_Ex),
    .MemRead_Ex(MemRead_Ex), .MemWrite_Ex(MemWrite_Ex),
    .MemtoReg_Ex(MemtoReg_Ex), .RegWrite_Ex(RegWrite_Ex),
    .Rd_Ex(Rd_Ex), .Rn_Ex(Rn_Ex), .Rm_Ex(Rm_Ex),
    .SignExt_Ex(SignExt_Ex), .ReadData1_Ex(ReadData1_Ex), .ReadData2_Ex(ReadData2_Ex),
    .Zero_Ex(Zero_Ex), .ALUResult_Mem(ALUResult_Mem), .Rd_Mem(Rd_Mem),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic as, input logic [2:0] op, input logic mr, input logic mw,
                       input logic m2r, input logic rw, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [63:0] imm, input logic [63:0] r1,
                       input logic [63:0] r2);
    ALUSrc_Ex = as; ALUOp_Ex = op; MemRead_Ex = mr; MemWrite_Ex = mw;
    MemtoReg_Ex = m2r; RegWrite_Ex = rw; Rd_Ex = rd; Rn_Ex = rn; Rm_Ex = rm;
    SignExt_Ex = imm; ReadData1_Ex = r1; ReadData2_Ex = r2;
    #1;
  endtask

  task automatic bubble();
    drive(0, 3'b000, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    bubble(); step(); step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bubble();
    #1 Reset = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b want 0", RegWrite); end
    checks++; if (WriteData !== 64'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", WriteData); end
    checks++; if (WriteReg !== 5'd0) begin errors++; $display("FAIL reset_wreg got %0d want 0", WriteReg); end
    checks++; if (Rd_Mem !== 5'd0 || ALUResult_Mem !== 64'd0) begin errors++;
      $display("FAIL reset_exmem got rd=%0d alu=%h want 0/0", Rd_Mem, ALUResult_Mem); end
    step(); step();
    Reset = 1'b1;
    flush();
  endtask

  task automatic test_add();
    drive(1, 3'b010, 0, 0, 0, 1, 5'd1, 5'd0, 5'd0, 64'd7, 64'd5, 64'd0);
    checks++; if (Zero_Ex !== 1'b0) begin errors++; $display("FAIL add_zero got %0b want 0", Zero_Ex); end
    step(); bubble();
    checks++; if (ALUResult_Mem !== 64'd12 || Rd_Mem !== 5'd1) begin errors++;
      $display("FAIL add_exmem got alu=%0d rd=%0d want 12/1", ALUResult_Mem, Rd_Mem); end
    step();
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd1 || WriteData !== 64'd12) begin errors++;
      $display("FAIL add_wb got rw=%0b reg=%0d data=%0d want 1/1/12", RegWrite, WriteReg, WriteData); end
    flush();
  endtask

  task automatic test_alu_ops();
    logic [2:0]  ops [9];
    logic [63:0] a   [9];
    logic [63:0] exp [9];
    ops[0]=3'b000; a[0]=64'hFF00; exp[0]=64'h0F00;
    ops[1]=3'b001; a[1]=64'hFF00; exp[1]=64'hFFF0;
    ops[2]=3'b010; a[2]=64'hFF00; exp[2]=64'h10EF0;
    ops[3]=3'b110; a[3]=64'hFF00; exp[3]=64'hEF10;
    ops[4]=3'b111; a[4]=64'hFF00; exp[4]=64'h0FF0;
    ops[5]=3'b011; a[5]=64'hFF00; exp[5]=64'd0;
    ops[6]=3'b100; a[6]=64'hFF00; exp[6]=64'd0;
    ops[7]=3'b101; a[7]=64'hFF00; exp[7]=64'd0;
    ops[8]=3'b110; a[8]=64'h0FE0; exp[8]=64'hFFFF_FFFF_FFFF_FFF0;
    for (int i = 0; i < 9; i++) begin
      drive(1, ops[i], 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 64'h0FF0, a[i], 64'd0);
      step();
      checks++; if (ALUResult_Mem !== exp[i]) begin errors++;
        $display("FAIL alu_op%0d got %h want %h", i, ALUResult_Mem, exp[i]); end
    end
    flush();
  endtask

  task automatic test_back_to_back();
    logic [63:0] orr_exp;
`ifdef BACKEND_FORWARDING_EN
    orr_exp = 64'd12;
`else
    orr_exp = 64'd0;
`endif
    drive(1, 3'b010, 0, 0, 0, 1, 5'd1, 5'd0, 5'd0, 64'd7, 64'd5, 64'd0);
    step();
    drive(0, 3'b110, 0, 0, 0, 1, 5'd2, 5'd1, 5'd1, 64'd0, 64'd0, 64'd0);
    checks++; if (Zero_Ex !== 1'b1) begin errors++; $display("FAIL b2b_sub_zero got %0b want 1", Zero_Ex); end
    step();
    drive(0, 3'b001, 0, 0, 0, 1, 5'd3, 5'd1, 5'd2, 64'd0, 64'd0, 64'd0);
    checks++; if (Zero_Ex !== (orr_exp == 64'd0)) begin errors++;
      $display("FAIL b2b_orr_zero got %0b want %0b", Zero_Ex, orr_exp == 64'd0); end
    checks++; if (WriteReg !== 5'd1 || WriteData !== 64'd12) begin errors++;
      $display("FAIL b2b_x1_wb got reg=%0d data=%0d want 1/12", WriteReg, WriteData); end
    step(); bubble();
    checks++; if (WriteReg !== 5'd2 || WriteData !== 64'd0 || RegWrite !== 1'b1) begin errors++;
      $display("FAIL b2b_x2_wb got reg=%0d data=%0d rw=%0b want 2/0/1", WriteReg, WriteData, RegWrite); end
    step();
    checks++; if (WriteReg !== 5'd3 || WriteData !== orr_exp) begin errors++;
      $display("FAIL b2b_x3_wb got reg=%0d data=%0d want 3/%0d", WriteReg, WriteData, orr_exp); end
    flush();
  endtask

  task automatic test_fwd_priority();
    logic [63:0] exp;
`ifdef BACKEND_FORWARDING_EN
    exp = 64'd2;
`else
    exp = 64'd0;
`endif
    drive(1, 3'b010, 0, 0, 0, 1, 5'd5, 5'd0, 5'd0, 64'd1, 64'd0, 64'd0);
    step();
    drive(1, 3'b010, 0, 0, 0, 1, 5'd5, 5'd0, 5'd0, 64'd2, 64'd0, 64'd0);
    step();
    drive(0, 3'b010, 0, 0, 0, 1, 5'd6, 5'd5, 5'd5, 64'd0, 64'd0, 64'd0);
    step();
    checks++; if (ALUResult_Mem !== 2 * exp) begin errors++;
      $display("FAIL fwd_priority got %0d want %0d", ALUResult_Mem, 2 * exp); end
    flush();
  endtask

  task automatic test_store_load();
    // STUR X9 -> [0x18], then LDUR X4 from wrapped address 0x818
    drive(1, 3'b010, 0, 1, 0, 0, 5'd9, 5'd10, 5'd9, 64'h8, 64'h10, 64'hDEAD_BEEF);
    step();
    drive(1, 3'b010, 1, 0, 1, 1, 5'd4, 5'd10, 5'd0, 64'd0, 64'h818, 64'd0);
    checks++; if (ALUResult_Mem !== 64'h18) begin errors++; $display("FAIL stur_addr got %h want 18", ALUResult_Mem); end
    step(); bubble(); step();
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd4 || WriteData !== 64'hDEAD_BEEF) begin errors++;
      $display("FAIL ldur_wrap got rw=%0b reg=%0d data=%h want 1/4/deadbeef", RegWrite, WriteReg, WriteData); end
    flush();
    // Store, illegal read+write, then a load of the same word
    drive(1, 3'b010, 0, 1, 0, 0, 5'd12, 5'd13, 5'd12, 64'h28, 64'd0, 64'h1111);
    step();
    drive(1, 3'b010, 1, 1, 1, 1, 5'd7, 5'd13, 5'd12, 64'h28, 64'd0, 64'h2222);
    step();
    drive(1, 3'b010, 1, 0, 1, 1, 5'd11, 5'd13, 5'd0, 64'h28, 64'd0, 64'd0);
    step(); bubble();
    checks++; if (WriteReg !== 5'd7 || WriteData !== 64'h1111) begin errors++;
      $display("FAIL rdwr_old got reg=%0d data=%h want 7/1111", WriteReg, WriteData); end
    step();
    checks++; if (WriteReg !== 5'd11 || WriteData !== 64'h2222) begin errors++;
      $display("FAIL rdwr_commit got reg=%0d data=%h want 11/2222", WriteReg, WriteData); end
    flush();
  endtask

  task automatic test_xzr();
    drive(1, 3'b010, 0, 0, 0, 1, 5'd31, 5'd0, 5'd0, 64'd7, 64'd5, 64'd0);
    step();
    drive(1, 3'b010, 0, 0, 0, 1, 5'd8, 5'd31, 5'd0, 64'd0, 64'd0, 64'd0);
    checks++; if (Zero_Ex !== 1'b1) begin errors++; $display("FAIL xzr_nofwd got zero=%0b want 1", Zero_Ex); end
    step(); bubble();
    checks++; if (RegWrite !== 1'b0 || WriteReg !== 5'd31) begin errors++;
      $display("FAIL xzr_suppress got rw=%0b reg=%0d want 0/31", RegWrite, WriteReg); end
    step();
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd8 || WriteData !== 64'd0) begin errors++;
      $display("FAIL xzr_reader got rw=%0b reg=%0d data=%0d want 1/8/0", RegWrite, WriteReg, WriteData); end
    flush();
  endtask

  task automatic test_reset_mid();
    // ADD in MEM when reset pulses
    drive(1, 3'b010, 0, 0, 0, 1, 5'd9, 5'd0, 5'd0, 64'd4, 64'd3, 64'd0);
    step(); bubble();
    checks++; if (Rd_Mem !== 5'd9 || ALUResult_Mem !== 64'd7) begin errors++;
      $display("FAIL rstmid_pre got rd=%0d alu=%0d want 9/7", Rd_Mem, ALUResult_Mem); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (Rd_Mem !== 5'd0 || ALUResult_Mem !== 64'd0 || RegWrite !== 1'b0 || WriteData !== 64'd0) begin errors++;
      $display("FAIL rstmid_async got rd=%0d alu=%0d rw=%0b data=%0d want 0/0/0/0", Rd_Mem, ALUResult_Mem, RegWrite, WriteData); end
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b0 || WriteData !== 64'd0) begin errors++;
      $display("FAIL rstmid_hold got rw=%0b data=%0d want 0/0", RegWrite, WriteData); end
    #1 Reset = 1'b1;
    step();
    checks++; if (RegWrite !== 1'b0 || WriteReg !== 5'd0) begin errors++;
      $display("FAIL rstmid_dropped got rw=%0b reg=%0d want 0/0", RegWrite, WriteReg); end
    flush();
    // Store in MEM across a reset edge must not commit
    drive(1, 3'b010, 0, 1, 0, 0, 5'd15, 5'd16, 5'd15, 64'h30, 64'd0, 64'hAAAA);
    step(); flush();
    drive(1, 3'b010, 0, 1, 0, 0, 5'd15, 5'd16, 5'd15, 64'h30, 64'd0, 64'hBBBB);
    step(); bubble();
    #2 Reset = 1'b0;
    @(posedge clk); #2 Reset = 1'b1;
    step();
    drive(1, 3'b010, 1, 0, 1, 1, 5'd14, 5'd16, 5'd0, 64'h30, 64'd0, 64'd0);
    step(); bubble(); step();
    checks++; if (WriteReg !== 5'd14 || WriteData !== 64'hAAAA) begin errors++;
      $display("FAIL rstmid_store got reg=%0d data=%h want 14/aaaa", WriteReg, WriteData); end
    flush();
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_back_to_back();
    test_fwd_priority();
    test_store_load();
    test_xzr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
